// File: rtl/cam_pattern_tx_if.sv
`default_nettype none
// ==========================================================================
// cam_pattern_tx_if : control inputs and DVP-style camera bus of the
//                     test-pattern transmitter.
// Revision: 1.0
// ==========================================================================
interface cam_pattern_tx_if;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] color;
  logic        PCLK;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  D;
  logic        frame_done;

  // master = the transmitter driving the camera bus
  modport master (
    input  enable, mode, color,
    output PCLK, VSYNC, HREF, D, frame_done
  );

  modport slave (
    output enable, mode, color,
    input  PCLK, VSYNC, HREF, D, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/cam_pattern_tx.sv
`default_nettype none
// ==========================================================================
// cam_pattern_tx : emits framed RGB565 test patterns on a DVP-style bus.
// Revision: 1.0
// ==========================================================================
module cam_pattern_tx #(
  parameter int H_ACT    = 320,
  parameter int V_ACT    = 240,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cam_pattern_tx_if.master cam
);

  localparam int c_LINE  = 2 * H_ACT + H_BLANK;
  localparam int c_HW    = (c_LINE > 1) ? $clog2(c_LINE) : 1;
  localparam int c_VSUM  = VS_LINES + V_BACK + V_ACT + V_FRONT;
  localparam int c_VW    = $clog2(c_VSUM + 1);
  localparam int c_BAR_W = (H_ACT >= 8) ? (H_ACT / 8) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_pclk;
  logic [c_HW-1:0]   r_hcnt;
  logic [c_VW-1:0]   r_lcnt;
  logic [1:0]        r_mode;
  logic [15:0]       r_color;
  logic              r_vsync;
  logic              r_href;
  logic [7:0]        r_d;
  logic              r_fd;

  state_t            w_nstate;
  logic [c_HW-1:0]   w_nh;
  logic [c_VW-1:0]   w_nl;
  logic              w_tick;
  logic              w_line_end;
  logic              w_lcnt_last;
  logic              w_frame_end;
  logic              w_latch;
  logic [15:0]       w_x;
  logic [15:0]       w_y;
  logic [15:0]       w_bar;
  logic [15:0]       w_pix;
  logic              w_href_n;
  logic [7:0]        w_d_n;

  // Everything but PCLK advances on the clk edge where PCLK falls.
  assign w_tick     = r_pclk;
  assign w_line_end = (r_hcnt == c_HW'(c_LINE - 1));

  always_comb begin
    w_lcnt_last = 1'b0;
    case (r_state)
      ST_VS:     w_lcnt_last = (r_lcnt == c_VW'(VS_LINES - 1));
      ST_VBACK:  w_lcnt_last = (r_lcnt == c_VW'(V_BACK - 1));
      ST_ACTIVE: w_lcnt_last = (r_lcnt == c_VW'(V_ACT - 1));
      ST_VFRONT: w_lcnt_last = (r_lcnt == c_VW'(V_FRONT - 1));
      default:   w_lcnt_last = 1'b0;
    endcase
  end

  always_comb begin
    w_nstate    = r_state;
    w_nh        = r_hcnt;
    w_nl        = r_lcnt;
    w_frame_end = 1'b0;
    w_latch     = 1'b0;
    if (r_state == ST_IDLE) begin
      if (cam.enable) begin
        w_nstate = ST_VS;
        w_latch  = 1'b1;
      end
    end else if (!w_line_end) begin
      w_nh = r_hcnt + c_HW'(1);
    end else begin
      w_nh = '0;
      if (!w_lcnt_last) begin
        w_nl = r_lcnt + c_VW'(1);
      end else begin
        w_nl = '0;
        case (r_state)
          ST_VS:     w_nstate = ST_VBACK;
          ST_VBACK:  w_nstate = ST_ACTIVE;
          ST_ACTIVE: w_nstate = ST_VFRONT;
          ST_VFRONT: begin
            // Back-to-back frames skip IDLE so VS follows immediately.
            w_frame_end = 1'b1;
            if (cam.enable) begin
              w_nstate = ST_VS;
              w_latch  = 1'b1;
            end else begin
              w_nstate = ST_IDLE;
            end
          end
          default:   w_nstate = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are computed for the PCLK period that starts at this tick.
  assign w_x      = 16'(w_nh >> 1);
  assign w_y      = 16'(w_nl);
  assign w_bar    = w_x / 16'(c_BAR_W);
  assign w_href_n = (w_nstate == ST_ACTIVE) && (w_nh < c_HW'(2 * H_ACT));

  always_comb begin
    w_pix = 16'h0000;
    case (r_mode)
      2'b00: begin
        case (w_bar)
          16'd0:   w_pix = 16'hFFFF;
          16'd1:   w_pix = 16'hFFE0;
          16'd2:   w_pix = 16'h07FF;
          16'd3:   w_pix = 16'h07E0;
          16'd4:   w_pix = 16'hF81F;
          16'd5:   w_pix = 16'hF800;
          16'd6:   w_pix = 16'h001F;
          default: w_pix = 16'h0000;
        endcase
      end
      2'b01:   w_pix = r_color;
      2'b10:   w_pix = w_x + w_y;
      default: w_pix = (w_x[3] ^ w_y[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_comb begin
    w_d_n = 8'h00;
    if (w_href_n) begin
      w_d_n = w_nh[0] ? w_pix[7:0] : w_pix[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pclk  <= 1'b0;
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_mode  <= 2'b00;
      r_color <= 16'h0000;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_d     <= 8'h00;
      r_fd    <= 1'b0;
    end else begin
      r_pclk <= ~r_pclk;
      r_fd   <= 1'b0;
      if (w_tick) begin
        r_state <= w_nstate;
        r_hcnt  <= w_nh;
        r_lcnt  <= w_nl;
        r_vsync <= (w_nstate == ST_VS);
        r_href  <= w_href_n;
        r_d     <= w_d_n;
        r_fd    <= w_frame_end;
        if (w_latch) begin
          r_mode  <= cam.mode;
          r_color <= cam.color;
        end
      end
    end
  end

  assign cam.PCLK       = r_pclk;
  assign cam.VSYNC      = r_vsync;
  assign cam.HREF       = r_href;
  assign cam.D          = r_d;
  assign cam.frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_cam_pattern_tx.sv
`default_nettype none
// ==========================================================================
// tb_cam_pattern_tx : random-stimulus bench for cam_pattern_tx against a
//                     frame-position reference model (reduced geometry).
// Revision: 1.0
// ==========================================================================
module tb_cam_pattern_tx;

  localparam int H_ACT    = 16;
  localparam int V_ACT    = 20;
  localparam int H_BLANK  = 6;
  localparam int VS_LINES = 2;
  localparam int V_BACK   = 2;
  localparam int V_FRONT  = 2;
  localparam int LINE     = 2 * H_ACT + H_BLANK;
  localparam int FRAME    = (VS_LINES + V_BACK + V_ACT + V_FRONT) * LINE;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic clk = 1'b0;
  logic rst = 1'b1;

  cam_pattern_tx_if cam ();

  cam_pattern_tx #(
    .H_ACT    (H_ACT),
    .V_ACT    (V_ACT),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pattern(input logic [1:0] md, input logic [15:0] col,
                                          input int x, input int y);
    int b;
    case (md)
      2'b00: begin
        b = x / (H_ACT / 8);
        if (b > 7) b = 7;
        return BARS[b];
      end
      2'b01:   return col;
      2'b10:   return 16'(x + y);
      default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Reference model: PCLK phase, frame-in-progress flag, PCLK periods into frame.
  bit          m_ph    = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_pos   = 0;
  logic [1:0]  m_mode  = 2'b00;
  logic [15:0] m_color = 16'h0000;
  bit          m_fd    = 1'b0;

  longint cyc       = 0;
  int     fd_cnt    = 0;
  int     href_rise = 0;
  longint fd_t[$];
  logic   href_prev = 1'b0;

  initial begin
    forever begin : mon
      int          line, h, al;
      logic        e_vs, e_href;
      logic [7:0]  e_d;
      logic [15:0] px;
      @(negedge clk);
      cyc++;
      e_vs = 1'b0; e_href = 1'b0; e_d = 8'h00;
      if (m_busy) begin
        line   = m_pos / LINE;
        h      = m_pos % LINE;
        al     = line - VS_LINES - V_BACK;
        e_vs   = (line < VS_LINES);
        e_href = (al >= 0) && (al < V_ACT) && (h < 2 * H_ACT);
        if (e_href) begin
          px  = pattern(m_mode, m_color, h / 2, al);
          e_d = (h % 2 == 1) ? px[7:0] : px[15:8];
        end
      end
      check("PCLK",       32'(cam.PCLK),       32'(m_ph));
      check("VSYNC",      32'(cam.VSYNC),      32'(e_vs));
      check("HREF",       32'(cam.HREF),       32'(e_href));
      check("D",          32'(cam.D),          32'(e_d));
      check("frame_done", 32'(cam.frame_done), 32'(m_fd));

      if (cam.frame_done === 1'b1) begin
        fd_cnt++;
        fd_t.push_back(cyc);
      end
      if (cam.HREF === 1'b1 && href_prev !== 1'b1) href_rise++;
      href_prev = cam.HREF;

      // Advance the model across the coming clk edge using inputs stable now.
      if (rst) begin
        m_ph = 1'b0; m_busy = 1'b0; m_pos = 0; m_fd = 1'b0;
      end else begin
        m_fd = 1'b0;
        if (m_ph) begin
          if (!m_busy) begin
            if (cam.enable) begin
              m_busy = 1'b1; m_pos = 0; m_mode = cam.mode; m_color = cam.color;
            end
          end else if (m_pos == FRAME - 1) begin
            m_fd = 1'b1;
            if (cam.enable) begin
              m_pos = 0; m_mode = cam.mode; m_color = cam.color;
            end else begin
              m_busy = 1'b0;
            end
          end else begin
            m_pos++;
          end
        end
        m_ph = ~m_ph;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int   base_fd, base_h, branch, fd_first;
    logic p1, p2;
    cam.enable = 1'b0;
    cam.mode   = 2'b00;
    cam.color  = 16'h0000;
    run(3);

    // Two back-to-back colour-bar frames.
    rst        = 1'b0;
    cam.enable = 1'b1;
    cam.mode   = 2'b00;
    cam.color  = 16'($urandom);
    base_fd    = fd_cnt;
    base_h     = href_rise;
    fd_first   = fd_t.size();
    run(2 * FRAME * 2 + 40);
    check("two_frame_fd_count", 32'(fd_cnt - base_fd), 32'd2);
    check("two_frame_href_lines", 32'(href_rise - base_h), 32'(2 * V_ACT));
    check("fd_spacing",
          (fd_t.size() >= fd_first + 2) ? 32'(fd_t[fd_first + 1] - fd_t[fd_first]) : 32'd0,
          32'(2 * FRAME));

    for (int it = 0; it < 8; it++) begin
      cam.mode   = 2'(it);
      cam.color  = 16'($urandom);
      cam.enable = 1'b1;
      run($urandom_range(FRAME / 2, 2 * FRAME));
      // Mid-frame input changes must not affect the frame in flight.
      cam.mode  = 2'($urandom);
      cam.color = 16'($urandom);
      branch = (it == 2) ? 0 : (it == 5) ? 1 : int'($urandom_range(0, 3));
      case (branch)
        0: begin
          cam.enable = 1'b0;
          run(2 * FRAME + int'($urandom_range(10, 200)));
        end
        1: begin
          rst = 1'b1;
          run($urandom_range(1, 3));
          rst = 1'b0;
        end
        default: run($urandom_range(10, FRAME));
      endcase
    end

    cam.enable = 1'b0;
    run(2 * FRAME + 50);
    @(negedge clk);
    check("idle_VSYNC", 32'(cam.VSYNC), 32'd0);
    check("idle_HREF",  32'(cam.HREF),  32'd0);
    check("idle_D",     32'(cam.D),     32'd0);
    p1 = cam.PCLK;
    @(negedge clk);
    p2 = cam.PCLK;
    check("idle_pclk_toggle", 32'(p1 ^ p2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_pattern_tx.md
CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

Interface
REQ-001 Parameter H_ACT, default 320, active pixels per line.
REQ-002 Parameter V_ACT, default 240, active lines per frame.
REQ-003 Parameter H_BLANK, default 144, PCLK periods with HREF low after each line.
REQ-004 Parameter VS_LINES, default 3, line periods with VSYNC high.
REQ-005 Parameter V_BACK, default 17, blank line periods after VSYNC.
REQ-006 Parameter V_FRONT, default 10, blank line periods after the last active line.
REQ-007 clk  input  1  single clock for all logic; one clock domain.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  frame generation request.
REQ-010 mode  input  2  pattern select.
REQ-011 color  input  16  RGB565 value for solid mode.
REQ-012 PCLK  output  1  pixel clock, clk/2.
REQ-013 VSYNC  output  1  frame sync, active high.
REQ-014 HREF  output  1  line valid, active high.
REQ-015 D  output  8  pixel byte.
REQ-016 frame_done  output  1  one-clk pulse at end of each frame.

Function
REQ-017 PCLK SHALL toggle on every clk edge when not in reset; period = 2 clk.
REQ-018 Tick = clk edge where the PCLK register is 1 (PCLK falling); VSYNC, HREF, D, counters and state SHALL update only on ticks, so they are stable at PCLK rising.
REQ-019 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-020 States: IDLE, VS, VBACK, ACTIVE, VFRONT; line period = 2*H_ACT + H_BLANK PCLK periods (784 default).
REQ-021 IDLE: VSYNC=HREF=0, D=0; on tick with enable=1 -> VS, latch mode and color.
REQ-022 VS: VSYNC=1 for VS_LINES line periods -> VBACK.
REQ-023 VBACK: V_BACK line periods, all low -> ACTIVE.
REQ-024 ACTIVE: per line, HREF=1 for 2*H_ACT ticks then 0 for H_BLANK ticks; after V_ACT lines -> VFRONT.
REQ-025 D SHALL be 0 whenever HREF=0.
REQ-026 Each pixel SHALL be two bytes, RGB565 high byte [15:8] first, low byte [7:0] second.
REQ-027 Pixel x = 0..H_ACT-1, line y = 0..V_ACT-1, counters reset each line/frame.
REQ-028 mode 00: 8 vertical bars, width H_ACT/8, order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
REQ-029 mode 01: every pixel = latched color.
REQ-030 mode 10: pixel = (x + y) zero-extended/truncated to 16 bits.
REQ-031 mode 11: checkerboard, pixel = FFFF if x[3]^y[3] else 0000.
REQ-032 VFRONT: V_FRONT line periods, all low; on its last tick frame_done=1 for that one clk; then enable=1 -> VS (new latch) else -> IDLE.
REQ-033 mode/color changes mid-frame SHALL be ignored until next frame latch.
REQ-034 enable deassert mid-frame SHALL NOT truncate the frame; frame completes, then IDLE.

Reset
REQ-035 rst=1 SHALL on the next clk edge force PCLK=0, VSYNC=0, HREF=0, D=0, frame_done=0, state IDLE, all counters 0, regardless of state (mid-line abort allowed).
REQ-036 After rst release, first PCLK rise on the first clk edge; first possible VS entry on the following tick.

Verification
REQ-037 Reset, enable=1, mode=00 -> VSYNC high 3*784 PCLK periods; exactly 240 HREF pulses of 640 PCLK each; first bytes FF,FF; bytes 80,81 = FF,E0; last pixel bytes 00,00.
REQ-038 mode=01, color=1234 -> every HREF byte pair 12,34; D=00 while HREF=0.
REQ-039 mode=11 -> line 0 pixels 0-7 = 0000, 8-15 = FFFF; line 8 pixels 0-7 = FFFF.
REQ-040 enable dropped at line 100, mode changed to 01 -> frame completes in mode 00, frame_done single pulse, then IDLE with outputs low; PCLK keeps toggling.
REQ-041 rst asserted mid-HREF -> next clk PCLK=VSYNC=HREF=0, D=00; on release with enable=1, a full frame restarts from VS.
REQ-042 enable held 1 for two frames -> frame_done pulses exactly 270*784*2 clk apart; VS follows VFRONT with no IDLE gap.
